// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start detect, 8N1/8P1 deserialization,
// majority-vote bit sampling, parity/stop checking with one-cycle result strobes.
module uart_rx_deframer #(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_S0   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] CNT_DEC  = CW'(PRESCALE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    smp_q, smp_d;
    logic [7:0]    shift_q, shift_d;
    logic          pen_q, pen_d;
    logic          ptyp_q, ptyp_d;
    logic          perr_q, perr_d;
    logic [7:0]    pdata_q, pdata_d;
    logic          dv_q, dv_d;
    logic          pe_q, pe_d;
    logic          se_q, se_d;
    logic          maj;

    assign rx_s = sync_q[1];

    // Synchronizer and edge history idle high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
            prev_q <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            perr_q  <= 1'b0;
            pdata_q <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            perr_q  <= perr_d;
            pdata_q <= pdata_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    // Third sample is the live line value at the decision count
    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        perr_d  = perr_q;
        pdata_d = pdata_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            if (cnt_q == CNT_S0) smp_d[0] = rx_s;
            if (cnt_q == CNT_S1) smp_d[1] = rx_s;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge cycle is count 0 of the start bit
                if (!rx_s && prev_q) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                    bit_d   = '0;
                    pen_d   = PAR_EN;
                    ptyp_d  = PAR_TYP;
                    perr_d  = 1'b0;
                end
            end
            START: begin
                if (cnt_q == CNT_DEC && maj) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_DEC) shift_d = {maj, shift_q[7:1]};
                if (cnt_q == CNT_LAST) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = pen_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_DEC) perr_d = ((^shift_q) ^ maj) != ptyp_q;
                if (cnt_q == CNT_LAST) state_d = STOP;
            end
            STOP: begin
                if (cnt_q == CNT_DEC) begin
                    se_d    = ~maj;
                    pe_d    = perr_q;
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (maj && !perr_q) begin
                        dv_d    = 1'b1;
                        pdata_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at PRESCALE=8; a negedge monitor logs strobes
// with cycle stamps and each scenario task checks its own expectations.
module tb_uart_rx_deframer;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_pe  = 0;
    int n_se  = 0;
    int pe_cyc = -1;
    int se_cyc = -1;
    int         dv_cyc[$];
    logic [7:0] dv_dat[$];

    uart_rx_deframer #(.PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_DATA);
        end
        if (par_err) begin n_pe++; pe_cyc = cyc; end
        if (stp_err) begin n_se++; se_cyc = cyc; end
    end

    function automatic logic [7:0] dat_at(int i);
        return (i < dv_dat.size()) ? dv_dat[i] : 8'hxx;
    endfunction

    function automatic int cyc_at(int i);
        return (i < dv_cyc.size()) ? dv_cyc[i] : -1;
    endfunction

    // Drives one frame from a negedge; start pin edge lands at returned st.
    // abort_at != 0 asserts reset at that cycle offset and returns early.
    task automatic send(input logic [7:0] b, input bit pe, input bit pb, input bit sb,
                        input bit noise, input int abort_at, output int st);
        logic [10:0] fr;
        int nb;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
        if (pe) begin fr[9] = pb; fr[10] = sb; nb = 11; end
        else    begin fr[9] = sb; nb = 10; end
        st = cyc;
        for (int k = 0; k < nb; k++) begin
            for (int o = 0; o < P; o++) begin
                if (abort_at != 0 && k * P + o == abort_at) begin
                    rst = 1'b0;
                    RX_IN = 1'b1;
                    return;
                end
                RX_IN = fr[k];
                if (noise && o == 3 + (k % 3)) RX_IN = ~fr[k];
                @(negedge clk);
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL reset_pdata got=%h exp=00", P_DATA); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
        total++; if (par_err !== 1'b0) begin bad++; $display("FAIL reset_pe got=%b exp=0", par_err); end
        total++; if (stp_err !== 1'b0) begin bad++; $display("FAIL reset_se got=%b exp=0", stp_err); end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (dv_cyc.size() + n_pe + n_se != 0) begin bad++; $display("FAIL idle_quiet got=%0d strobes exp=0", dv_cyc.size() + n_pe + n_se); end
    endtask

    task automatic test_parity_ok();
        int n0, pe0, se0, st;
        n0 = dv_cyc.size(); pe0 = n_pe; se0 = n_se;
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 0, st);
        repeat (4) @(negedge clk);
        total++; if (dv_cyc.size() != n0 + 1) begin bad++; $display("FAIL par_ok_count got=%0d exp=%0d", dv_cyc.size(), n0 + 1); end
        total++; if (cyc_at(n0) != st + 88) begin bad++; $display("FAIL par_ok_time got=%0d exp=%0d", cyc_at(n0), st + 88); end
        total++; if (dat_at(n0) !== 8'hA5) begin bad++; $display("FAIL par_ok_data got=%h exp=a5", dat_at(n0)); end
        total++; if (n_pe != pe0) begin bad++; $display("FAIL par_ok_pe got=%0d exp=%0d", n_pe, pe0); end
        total++; if (n_se != se0) begin bad++; $display("FAIL par_ok_se got=%0d exp=%0d", n_se, se0); end
    endtask

    task automatic test_parity_err();
        int n0, pe0, se0, st;
        n0 = dv_cyc.size(); pe0 = n_pe; se0 = n_se;
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 0, st);
        repeat (4) @(negedge clk);
        total++; if (n_pe != pe0 + 1) begin bad++; $display("FAIL par_err_count got=%0d exp=%0d", n_pe, pe0 + 1); end
        total++; if (pe_cyc != st + 88) begin bad++; $display("FAIL par_err_time got=%0d exp=%0d", pe_cyc, st + 88); end
        total++; if (dv_cyc.size() != n0) begin bad++; $display("FAIL par_err_nodv got=%0d exp=%0d", dv_cyc.size(), n0); end
        total++; if (n_se != se0) begin bad++; $display("FAIL par_err_se got=%0d exp=%0d", n_se, se0); end
        total++; if (P_DATA !== 8'hA5) begin bad++; $display("FAIL par_err_hold got=%h exp=a5", P_DATA); end
    endtask

    task automatic test_stop_err();
        int n0, pe0, se0, st;
        n0 = dv_cyc.size(); pe0 = n_pe; se0 = n_se;
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0, st);
        repeat (4) @(negedge clk);
        total++; if (n_se != se0 + 1) begin bad++; $display("FAIL stp_err_count got=%0d exp=%0d", n_se, se0 + 1); end
        total++; if (se_cyc != st + 80) begin bad++; $display("FAIL stp_err_time got=%0d exp=%0d", se_cyc, st + 80); end
        total++; if (dv_cyc.size() != n0) begin bad++; $display("FAIL stp_err_nodv got=%0d exp=%0d", dv_cyc.size(), n0); end
        total++; if (P_DATA !== 8'hA5) begin bad++; $display("FAIL stp_err_hold got=%h exp=a5", P_DATA); end
        repeat (10) @(negedge clk);
        send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 0, st);
        repeat (4) @(negedge clk);
        total++; if (cyc_at(n0) != st + 80) begin bad++; $display("FAIL stp_retry_time got=%0d exp=%0d", cyc_at(n0), st + 80); end
        total++; if (dat_at(n0) !== 8'h3C) begin bad++; $display("FAIL stp_retry_data got=%h exp=3c", dat_at(n0)); end
        total++; if (n_pe != pe0) begin bad++; $display("FAIL stp_retry_pe got=%0d exp=%0d", n_pe, pe0); end
    endtask

    task automatic test_glitch();
        int n0, pe0, se0, st, st2;
        n0 = dv_cyc.size(); pe0 = n_pe; se0 = n_se;
        PAR_EN = 1'b0;
        repeat (5) @(negedge clk);
        st = cyc;
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (4) @(negedge clk);
        // Next start edge reaches the deframer exactly when it is back in IDLE
        send(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 0, st2);
        repeat (4) @(negedge clk);
        total++; if (dv_cyc.size() != n0 + 1) begin bad++; $display("FAIL glitch_count got=%0d exp=%0d", dv_cyc.size(), n0 + 1); end
        total++; if (cyc_at(n0) != st + 86) begin bad++; $display("FAIL glitch_time got=%0d exp=%0d", cyc_at(n0), st + 86); end
        total++; if (dat_at(n0) !== 8'h81) begin bad++; $display("FAIL glitch_data got=%h exp=81", dat_at(n0)); end
        total++; if (n_pe + n_se != pe0 + se0) begin bad++; $display("FAIL glitch_err got=%0d exp=%0d", n_pe + n_se, pe0 + se0); end
    endtask

    task automatic test_back_to_back();
        int n0, pe0, se0, st1, st2;
        n0 = dv_cyc.size(); pe0 = n_pe; se0 = n_se;
        PAR_EN = 1'b0;
        repeat (5) @(negedge clk);
        send(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, st1);
        send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 0, st2);
        repeat (4) @(negedge clk);
        total++; if (dv_cyc.size() != n0 + 2) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", dv_cyc.size(), n0 + 2); end
        total++; if (cyc_at(n0) != st1 + 80) begin bad++; $display("FAIL b2b_time0 got=%0d exp=%0d", cyc_at(n0), st1 + 80); end
        total++; if (cyc_at(n0 + 1) - cyc_at(n0) != 80) begin bad++; $display("FAIL b2b_gap got=%0d exp=80", cyc_at(n0 + 1) - cyc_at(n0)); end
        total++; if (dat_at(n0) !== 8'h00) begin bad++; $display("FAIL b2b_data0 got=%h exp=00", dat_at(n0)); end
        total++; if (dat_at(n0 + 1) !== 8'hFF) begin bad++; $display("FAIL b2b_data1 got=%h exp=ff", dat_at(n0 + 1)); end
        total++; if (n_pe + n_se != pe0 + se0) begin bad++; $display("FAIL b2b_err got=%0d exp=%0d", n_pe + n_se, pe0 + se0); end
    endtask

    task automatic test_reset_mid();
        int n0, pe0, se0, st;
        PAR_EN = 1'b0;
        repeat (5) @(negedge clk);
        // Data bit 4 is frame bit 5
        send(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 5 * P + 2, st);
        #1;
        total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL rst_mid_pdata got=%h exp=00", P_DATA); end
        total++; if ({data_valid, par_err, stp_err} !== 3'b000) begin bad++; $display("FAIL rst_mid_strobes got=%b exp=000", {data_valid, par_err, stp_err}); end
        repeat (3) @(negedge clk);
        total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL rst_mid_held got=%h exp=00", P_DATA); end
        rst = 1'b1;
        n0 = dv_cyc.size(); pe0 = n_pe; se0 = n_se;
        repeat (100) @(negedge clk);
        total++; if (dv_cyc.size() + n_pe + n_se != n0 + pe0 + se0) begin bad++; $display("FAIL rst_mid_abort got=%0d exp=%0d", dv_cyc.size() + n_pe + n_se, n0 + pe0 + se0); end
        send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 0, st);
        repeat (4) @(negedge clk);
        total++; if (cyc_at(n0) != st + 80) begin bad++; $display("FAIL rst_mid_time got=%0d exp=%0d", cyc_at(n0), st + 80); end
        total++; if (dat_at(n0) !== 8'h5A) begin bad++; $display("FAIL rst_mid_data got=%h exp=5a", dat_at(n0)); end
        total++; if (P_DATA !== 8'h5A) begin bad++; $display("FAIL rst_mid_pout got=%h exp=5a", P_DATA); end
    endtask

    initial begin
        test_reset();
        test_parity_ok();
        test_parity_err();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Receive-side counterpart of the UART transmit parity/framing path. It oversamples the serial line, detects start bits, and deserializes 8 data bits LSB first. It checks optional even/odd parity and the stop bit, then delivers the byte with a one-cycle valid strobe or error strobes. It sits between the RX pad and the receive FIFO/register bank, running on the system clock.

## Interface
- PRESCALE, 8, clock cycles per bit; even, ≥ 6
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line, idle high, asynchronous to clk
- PAR_EN  input  1  1 = frame carries a parity bit after the data
- PAR_TYP  input  1  1 = odd parity, 0 = even parity
- P_DATA  output  8  last correctly received byte
- data_valid  output  1  one-cycle strobe; P_DATA is new this cycle
- par_err  output  1  one-cycle strobe; parity mismatch in the frame just ended
- stp_err  output  1  one-cycle strobe; stop bit sampled 0

## Operation
- RX_IN passes through a 2-flop synchronizer, and both flops reset to 1. All behaviour below refers to the synchronized line, rx_s. A further flop holds the previous rx_s (prev) and resets to 1.
- States are IDLE, START, DATA, PARITY and STOP. An edge counter (0..PRESCALE-1) and a bit counter (0..7) drive the transitions.
- IDLE → START: rx_s=0 and prev=1, i.e. a falling edge. A line that is held low out of reset does not start a frame.
- PAR_EN and PAR_TYP are latched on the IDLE→START transition. Changes to them mid-frame have no effect.
- Each bit is sampled at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The bit value is the majority of the three samples, decided at count PRESCALE/2+1.
- START: a majority of 1 is a glitch. The block returns to IDLE on the next cycle with no strobes. A majority of 0 goes to DATA at the end of the bit period.
- DATA: data bit k is frame bit k+1, shifted LSB first. After bit 7 the block goes to PARITY if PAR_EN is set, otherwise to STOP.
- PARITY: computes ^data ^ par_bit. An error is flagged when the result ≠ PAR_TYP, so even parity expects 0 and odd parity expects 1.
- STOP: the stop bit is decided at count PRESCALE/2+1. On the next cycle the block asserts the strobes and returns to IDLE.
  - stp_err = 1 if the stop bit sampled 0.
  - par_err = 1 if a parity error was recorded.
  - data_valid = 1 only when neither error is set. P_DATA is loaded only in this case; otherwise it holds its previous value.
- par_err and stp_err may pulse in the same cycle.
- Reset (at any time, including mid-frame): state = IDLE, counters = 0, P_DATA = 0x00, all strobes 0, synchronizer and prev = 1.

## Timing
- Cycle t0 is the first IDLE cycle in which a falling edge of rx_s is seen. That cycle counts as edge count 0 of the start bit.
- Bit k occupies cycles t0+k·P through t0+k·P+P-1, where P = PRESCALE.
- S = 9 with no parity, 10 with parity.
- The strobes are visible exactly at cycle t0 + S·P + P/2 + 2, for one cycle. The state is IDLE in that same cycle.
- For P=8 that is t0+78 with no parity and t0+86 with parity.
- The earliest next start edge is accepted in the strobe cycle. Back-to-back frames with a full stop bit always work.
- Pin-to-rx_s latency is 2 cycles. This is not counted in t0.
- A start-bit glitch returns the block to IDLE at cycle t0 + P/2 + 2.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Byte 0xA5, PAR_EN=1, PAR_TYP=0, parity bit 0, stop bit 1, P=8: data_valid at t0+86 with P_DATA=0xA5; par_err=0 and stp_err=0 throughout.
- Byte 0xA5, PAR_EN=1, PAR_TYP=1, parity bit sent as 0: par_err at t0+86; data_valid stays 0; P_DATA unchanged.
- Byte 0x3C, PAR_EN=0, stop bit driven 0: stp_err at t0+78; no data_valid. Then send 0x3C correctly: data_valid with P_DATA=0x3C.
- RX_IN low for 2 cycles only (start glitch): no strobes; state back in IDLE by t0+6. A following valid frame of 0x81 is received correctly.
- Back-to-back frames 0x00 then 0xFF, PAR_EN=0, no idle gap: two data_valid pulses, 80 cycles apart, with P_DATA=0x00 then 0xFF. Also single-sample noise on one of the three sample points of each bit: bytes are still correct.
- Assert rst during data bit 4, release, then send 0x5A: all outputs are 0 during reset; no strobe for the aborted frame; 0x5A is received with data_valid.
